vga_mem_arbiter: RTL and testbench

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

---
 rtl/vga_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter
//   Shares one single-port pixel memory between the display scan-out and a
//   host write port. Host writes are queued in a small FIFO. Whenever the
//   display area is visible, the scan-out has absolute priority and issues
//   one read per cycle from a fetch counter. Queued writes drain only during
//   blanking.
//
//   Optional feature: define VGA_MEM_ARB_STATS_EN to add oa_stall_count.
//
// Ports
//   i_clk, i_reset        rising-edge clock, synchronous active-high reset
//   i_visible             display area visible (selects SCAN)
//   i_frame_sync          last line of frame; clears the fetch counter
//   i_wr_valid            host write request
//   ia_wr_addr/ia_wr_data host write address / data
//   o_wr_ready            host write accepted when i_wr_valid=1
//   oa_mem_addr/oa_mem_wdata/o_mem_en/o_mem_we  registered memory request
//   ia_mem_rdata          memory read data, one cycle after a read request
//   oa_pixel/o_pixel_valid fetched pixel stream, two cycles after SCAN
//   oa_stall_count        (stats build only) saturating host stall counter
module vga_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_visible,
  input  logic                  i_frame_sync,
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] ia_wr_addr,
  input  logic [DATA_WIDTH-1:0] ia_wr_data,
  output logic                  o_wr_ready,
  output logic [ADDR_WIDTH-1:0] oa_mem_addr,
  output logic [DATA_WIDTH-1:0] oa_mem_wdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  input  logic [DATA_WIDTH-1:0] ia_mem_rdata,
  output logic [DATA_WIDTH-1:0] oa_pixel,
  output logic                  o_pixel_valid
`ifdef VGA_MEM_ARB_STATS_EN
  ,
  output logic [15:0]           oa_stall_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, SCAN} state_t;

  logic [ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic                  full, empty, push, pop;
  logic [ADDR_WIDTH-1:0] fetch;
  state_t                next_state, state;

  assign full       = (count == (PW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  // Ready depends only on registered occupancy, so a same-cycle pop never
  // frees a slot early.
  assign o_wr_ready = ~full & ~i_reset;
  assign push       = i_wr_valid & o_wr_ready;
  assign pop        = (next_state == WRITE);

  // The decision is re-made every cycle from the inputs; the registered
  // state only records it so the pixel-valid pipeline can follow reads.
  // Occupancy is registered, so an entry pops no earlier than the cycle
  // after its push.
  always_comb begin
    next_state = IDLE;
    if (i_visible)   next_state = SCAN;
    else if (!empty) next_state = WRITE;
  end

  // Queue storage needs no reset: occupancy alone decides validity.
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_addr[wr_ptr] <= ia_wr_addr;
      q_data[wr_ptr] <= ia_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fetch         <= '0;
      state         <= IDLE;
      oa_mem_addr   <= '0;
      oa_mem_wdata  <= '0;
      o_mem_en      <= 1'b0;
      o_mem_we      <= 1'b0;
      o_pixel_valid <= 1'b0;
    end else begin
      state <= next_state;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase

      // Frame sync during a visible cycle reads address 0 and leaves the
      // counter pointing at the next pixel.
      if (i_frame_sync) fetch <= i_visible ? ADDR_WIDTH'(1) : '0;
      else if (i_visible) fetch <= fetch + 1'b1;

      case (next_state)
        SCAN: begin
          o_mem_en     <= 1'b1;
          o_mem_we     <= 1'b0;
          oa_mem_addr  <= i_frame_sync ? '0 : fetch;
          oa_mem_wdata <= '0;
        end
        WRITE: begin
          o_mem_en     <= 1'b1;
          o_mem_we     <= 1'b1;
          oa_mem_addr  <= q_addr[rd_ptr];
          oa_mem_wdata <= q_data[rd_ptr];
        end
        default: begin
          o_mem_en     <= 1'b0;
          o_mem_we     <= 1'b0;
          oa_mem_addr  <= '0;
          oa_mem_wdata <= '0;
        end
      endcase

      // A read presented last cycle returns data this cycle at the memory.
      o_pixel_valid <= (state == SCAN);
    end
  end

  assign oa_pixel = o_pixel_valid ? ia_mem_rdata : '0;

`ifdef VGA_MEM_ARB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset || i_frame_sync)
      oa_stall_count <= '0;
    else if (i_wr_valid && !o_wr_ready && oa_stall_count != 16'hFFFF)
      oa_stall_count <= oa_stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed testbench for vga_mem_arbiter with a one-cycle-latency memory
// model that returns addr+0x10 on reads.
module tb_vga_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset, visible, frame_sync, wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, pixel;
  logic        mem_en, mem_we, pixel_valid;
`ifdef VGA_MEM_ARB_STATS_EN
  logic [15:0] stall_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_visible     (visible),
    .i_frame_sync  (frame_sync),
    .i_wr_valid    (wr_valid),
    .ia_wr_addr    (wr_addr),
    .ia_wr_data    (wr_data),
    .o_wr_ready    (wr_ready),
    .oa_mem_addr   (mem_addr),
    .oa_mem_wdata  (mem_wdata),
    .o_mem_en      (mem_en),
    .o_mem_we      (mem_we),
    .ia_mem_rdata  (mem_rdata),
    .oa_pixel      (pixel),
    .o_pixel_valid (pixel_valid)
`ifdef VGA_MEM_ARB_STATS_EN
    ,
    .oa_stall_count(stall_count)
`endif
  );

  always_ff @(posedge clk)
    if (mem_en && !mem_we) mem_rdata <= mem_addr[7:0] + 8'h10;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem_rdata  = '0;
    reset      = 1'b1;
    visible    = 1'b0;
    frame_sync = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;

    // Reset: all outputs low for 3 cycles, ready right after release.
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_en", mem_en, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_pv", pixel_valid, 0);
      check("rst_pix", pixel, 0);
      check("rst_rdy", wr_ready, 0);
    end
    reset = 1'b0;
    #1;
    check("rel_rdy", wr_ready, 1);

    // Scan: reads 0..3, pixels 0x10..0x13 two cycles after each visible cycle.
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    visible = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      step();
      check("scan_en", mem_en, 1);
      check("scan_we", mem_we, 0);
      check("scan_addr", mem_addr, s - 1);
      if (s >= 2) begin
        check("scan_pv", pixel_valid, 1);
        check("scan_pix", pixel, 32'h10 + s - 2);
      end
    end
    visible = 1'b0;
    step();
    check("scan_idle_en", mem_en, 0);
    check("scan_last_pv", pixel_valid, 1);
    check("scan_last_pix", pixel, 32'h13);
    step();
    check("scan_end_pv", pixel_valid, 0);
    check("scan_end_pix", pixel, 0);

    // Write-full: 5 writes while visible, 4 accepted, drain in order.
    visible  = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_addr = 16'h0100 + 16'(i);
      wr_data = 8'hA0 + 8'(i);
      #1;
      check("full_rdy", wr_ready, (i < 4) ? 1 : 0);
      step();
    end
    wr_valid = 1'b0;
    visible  = 1'b0;
    for (int w = 0; w < 4; w++) begin
      step();
      check("drain_en", mem_en, 1);
      check("drain_we", mem_we, 1);
      check("drain_addr", mem_addr, 32'h100 + w);
      check("drain_data", mem_wdata, 32'hA0 + w);
    end
    step();
    check("drain_idle", mem_en, 0);
    check("drain_rdy", wr_ready, 1);

    // Preemption: second write waits behind a read issued at counter 9.
    wr_valid = 1'b1;
    wr_addr  = 16'h0200;
    wr_data  = 8'h55;
    step();
    wr_addr  = 16'h0201;
    wr_data  = 8'h66;
    step();
    check("pre_w1_we", mem_we, 1);
    check("pre_w1_addr", mem_addr, 32'h200);
    check("pre_w1_data", mem_wdata, 32'h55);
    wr_valid = 1'b0;
    visible  = 1'b1;
    step();
    check("pre_rd_en", mem_en, 1);
    check("pre_rd_we", mem_we, 0);
    check("pre_rd_addr", mem_addr, 9);
    visible = 1'b0;
    step();
    check("pre_w2_we", mem_we, 1);
    check("pre_w2_addr", mem_addr, 32'h201);
    check("pre_w2_data", mem_wdata, 32'h66);
    step();
    check("pre_idle", mem_en, 0);

    // Mid-operation reset discards the queued write and the in-flight pixel.
    visible  = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 16'h0300;
    wr_data  = 8'h77;
    step();
    wr_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("mrst_pv", pixel_valid, 0);
    check("mrst_en", mem_en, 0);
    check("mrst_rdy", wr_ready, 0);
    reset   = 1'b0;
    visible = 1'b0;
    step();
    check("mrst_noq", mem_en, 0);

    // Wrap: 2^16+1 visible cycles from counter 0, last read at address 0.
    visible = 1'b1;
    for (int k = 0; k < 65537; k++) begin
      step();
      if (k == 65535) check("wrap_max", mem_addr, 32'hFFFF);
    end
    check("wrap_zero", mem_addr, 0);

    // Frame sync while visible: read at 0, counter left at 1.
    frame_sync = 1'b1;
    step();
    check("fs_addr0", mem_addr, 0);
    frame_sync = 1'b0;
    step();
    check("fs_addr1", mem_addr, 1);
    visible = 1'b0;
    step();

`ifdef VGA_MEM_ARB_STATS_EN
    // Stats: fill the queue while visible, then 10 stalled cycles.
    reset = 1'b1;
    step();
    reset    = 1'b0;
    visible  = 1'b1;
    wr_valid = 1'b1;
    for (int c = 0; c < 4; c++) step();
    check("stat_zero", stall_count, 0);
    for (int c = 0; c < 10; c++) step();
    check("stat_ten", stall_count, 10);
    wr_valid   = 1'b0;
    frame_sync = 1'b1;
    step();
    check("stat_clr", stall_count, 0);
    frame_sync = 1'b0;
    visible    = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
